// File: rtl/ptp_ts_queue.sv
// PTP timestamp queue: latches RTC at SOP, pushes {ts, infor} on ptp_found, pops one entry per request.
// Optional build macro PTP_TS_QUEUE_MSGID_FILTER_EN adds msgid_mask to gate push requests by message id.
module ptp_ts_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_WIDTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    int_valid,
  input  logic                    int_sop,
  input  logic                    int_eop,
  input  logic [TS_WIDTH-1:0]     rtc_time,
  input  logic                    ptp_found,
  input  logic [19:0]             ptp_infor,
`ifdef PTP_TS_QUEUE_MSGID_FILTER_EN
  input  logic [15:0]             msgid_mask,
`endif
  input  logic                    q_clear,
  input  logic                    q_rd_en,
  output logic [TS_WIDTH+19:0]    q_rd_data,
  output logic                    q_rd_valid,
  output logic [DEPTH_LOG2:0]     q_count,
  output logic                    q_empty,
  output logic                    q_full,
  output logic [7:0]              q_ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = TS_WIDTH + 20;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [TS_WIDTH-1:0]   ts_sop_q, ts_sop_d;
  logic [TS_WIDTH-1:0]   ts_pend_q, ts_pend_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [7:0]            ovf_q, ovf_d;
  logic [EW-1:0]         rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [EW-1:0]         mem_q [0:DEPTH-1];

  logic push_req_s, push_ok_s, pop_ok_s, drop_s, wr_en_s;

  // Push/pop qualification
  always_comb begin
`ifdef PTP_TS_QUEUE_MSGID_FILTER_EN
    push_req_s = ptp_found && msgid_mask[ptp_infor[3:0]];
`else
    push_req_s = ptp_found;
`endif
    pop_ok_s  = q_rd_en && !empty_q;
    push_ok_s = push_req_s && (!full_q || pop_ok_s);
    drop_s    = push_req_s && full_q && !pop_ok_s;
    wr_en_s   = push_ok_s && !q_clear;
  end

  // Timestamp capture; SOP latch is kept separate so a following SOP cannot disturb the pending value
  always_comb begin
    ts_sop_d  = ts_sop_q;
    ts_pend_d = ts_pend_q;
    if (int_valid && int_sop) begin
      ts_sop_d = rtc_time;
    end else begin
      ts_sop_d = ts_sop_q;
    end
    if (int_valid && int_eop) begin
      ts_pend_d = int_sop ? rtc_time : ts_sop_q;
    end else begin
      ts_pend_d = ts_pend_q;
    end
  end

  // Queue bookkeeping and read port; q_clear overrides everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (q_clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ovf_d     = 8'h00;
      rd_data_d = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_ok_s && !push_ok_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
      if (drop_s && (ovf_q != 8'hFF)) begin
        ovf_d = ovf_q + 8'd1;
      end else begin
        ovf_d = ovf_q;
      end
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_sop_q   <= '0;
      ts_pend_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 8'h00;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ts_sop_q   <= ts_sop_d;
      ts_pend_q  <= ts_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Entry storage; only written slots are ever read, so no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {ts_pend_q, ptp_infor};
    end
  end

  assign q_rd_data  = rd_data_q;
  assign q_rd_valid = rd_valid_q;
  assign q_count    = count_q;
  assign q_empty    = empty_q;
  assign q_full     = full_q;
  assign q_ovf_cnt  = ovf_q;

endmodule

// File: doc/ptp_ts_queue.md
Name: ptp_ts_queue

Overview:
- Timestamp queue directly downstream of the PTP parser in the TSU.
- Latches the RTC time at packet SOP, which is the ingress/egress timestamp point.
- On a parser `ptp_found` pulse, pushes {timestamp, ptp_infor} into a synchronous FIFO.
- Host/register side pops entries one at a time; overflow drops are counted.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- TS_WIDTH, 64, width of the RTC time bus (e.g. 32-bit sec + 32-bit ns).

Ports:
- clk  input  1  clock, shared with the parser.
- rst  input  1  asynchronous, active-high reset.
- int_valid  input  1  packet bus valid, same bus that feeds the parser.
- int_sop  input  1  start of packet, qualified by int_valid.
- int_eop  input  1  end of packet, qualified by int_valid.
- rtc_time  input  TS_WIDTH  free-running RTC time.
- ptp_found  input  1  one-cycle pulse from the parser: previous packet is a PTP event.
- ptp_infor  input  20  {seqid[15:0], msgid[3:0]} from the parser, valid with ptp_found.
- q_clear  input  1  synchronous flush.
- q_rd_en  input  1  pop request.
- q_rd_data  output  TS_WIDTH+20  popped entry {ts, infor}; infor occupies the LSBs.
- q_rd_valid  output  1  one-cycle pulse, q_rd_data valid.
- q_count  output  DEPTH_LOG2+1  current occupancy.
- q_empty  output  1  q_count==0.
- q_full  output  1  q_count==2**DEPTH_LOG2.
- q_ovf_cnt  output  8  dropped-entry counter, saturating.

Behaviour:
- Reset values: all outputs 0 except q_empty=1; internal pointers and latches 0.
- Timestamp capture:
  - ts_sop <= rtc_time when int_valid && int_sop.
  - ts_pend <= ts_sop when int_valid && int_eop.
  - If sop and eop are asserted in the same cycle, ts_pend <= rtc_time.
  - Consequence: a back-to-back next SOP (parser result arrives 2 cycles after EOP) cannot corrupt the pending timestamp.
- Push request = ptp_found, entry = {ts_pend, ptp_infor}.
- Push accepted if not full, or if full with an accepted pop in the same cycle.
- Push while full without a pop: entry dropped; q_ovf_cnt increments, saturating at 8'hFF.
- Pop accepted when q_rd_en && !q_empty:
  - q_rd_data registered from the head entry at the next clock edge.
  - q_rd_valid=1 for exactly that cycle, so read latency is 1 clock.
  - q_rd_data holds its value until the next accepted pop.
- Pop when empty: ignored; q_rd_valid stays 0 and no pointer change.
- Simultaneous push and pop on an empty queue: the pop is ignored (FIFO is not fall-through); the push is accepted and count becomes 1.
- Simultaneous accepted push and pop otherwise: q_count unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth; q_count is tracked separately with DEPTH_LOG2+1 bits.
- q_empty and q_full are registered, coherent with q_count every cycle.
- q_clear:
  - Resets pointers, q_count, q_ovf_cnt and q_rd_valid; also clears q_rd_data to 0.
  - Has priority over push and pop in the same cycle.
  - Does not clear ts_sop or ts_pend.
- Storage: register array or inferred RAM. No reset on the array is required; the data path reads only written entries.

Optional Feature:
- Macro: PTP_TS_QUEUE_MSGID_FILTER_EN.
- Defined: adds input port msgid_mask [15:0]. A push request is taken only if msgid_mask[ptp_infor[3:0]]==1.
  - Masked-out requests are neither stored nor counted as overflow.
- Undefined: port absent; every ptp_found pulse is a push request.

Test Plan:
- Single packet: sop at rtc_time=64'h0000_0005_0000_0100, eop 20 cycles later, ptp_found with infor=20'h00120 -> q_count=1; pop gives q_rd_valid one cycle later and q_rd_data={64'h0000_0005_0000_0100, 20'h00120}.
- Back-to-back: packet A (sop ts=T1) eop, packet B sop (ts=T2) on the next cycle, ptp_found for A 2 cycles after A's eop -> stored ts=T1, not T2.
- Fill and overflow: 16 pushes, no pops -> q_full=1, q_count=16; then 3 more pushes -> q_ovf_cnt=3 and entries 0..15 pop in order with infor intact; 260 drops -> q_ovf_cnt=8'hFF.
- Full with simultaneous push and pop -> both accepted, q_count stays 16, q_ovf_cnt unchanged, wrap-around order preserved.
- Pop while empty -> no q_rd_valid, q_count=0; q_clear asserted together with push and pop at count 5 -> q_count=0, q_empty=1, q_ovf_cnt=0.
- Async reset mid-operation with count 7 -> all outputs at reset values immediately; with PTP_TS_QUEUE_MSGID_FILTER_EN and msgid_mask=16'h0001, infor msgid 0 is stored, msgid 2 is ignored with q_ovf_cnt unchanged.
